ledpanel_bcm: RTL

LEDPANEL_BCM -- requirements
Module: ledpanel_bcm

---
 rtl/ledpanel_bcm.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ledpanel_bcm.sv
// rtl/ledpanel_bcm.sv - HUB75-style LED panel driver with binary-coded-modulation scan and a byte-addressed control bus
module ledpanel_bcm #(
  parameter int BITS_PER_CHANNEL = 4,
  parameter int PANEL_W          = 32,
  parameter int CHAINED          = 1,
  parameter int SCAN_ROWS        = 16,
  parameter int DOUBLE_BUFFER    = 1,
  parameter int BLANK_CYCLES     = 2,
  parameter int BRIGHT_RESET     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [15:0] ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  output logic        panel_r0,
  output logic        panel_g0,
  output logic        panel_b0,
  output logic        panel_r1,
  output logic        panel_g1,
  output logic        panel_b1,
  output logic [4:0]  panel_addr,
  output logic        panel_clk,
  output logic        panel_stb,
  output logic        panel_oe
);

  localparam int NCOL  = PANEL_W * CHAINED;
  localparam int NPIX  = 2 * SCAN_ROWS * NCOL;
  localparam int NBUF  = (DOUBLE_BUFFER != 0) ? 2 : 1;
  localparam int DEPTH = NBUF * NPIX;
  localparam int MW    = $clog2(DEPTH);
  localparam int YW    = $clog2(SCAN_ROWS);
  localparam int ZW    = (BITS_PER_CHANNEL > 1) ? $clog2(BITS_PER_CHANNEL) : 1;
  localparam int CW    = 24;
  localparam logic              DB          = (DOUBLE_BUFFER != 0);
  localparam logic [31:0]       NCOL32      = 32'(NCOL);
  localparam logic [31:0]       NPIX32      = 32'(NPIX);
  localparam logic [31:0]       HALF32      = 32'(SCAN_ROWS * NCOL);
  localparam logic [CW-1:0]     SHIFT_LAST  = CW'(2 * NCOL - 1);
  localparam logic [CW-1:0]     BLANK_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [ZW-1:0]     Z_LAST      = ZW'(BITS_PER_CHANNEL - 1);
  localparam logic [YW-1:0]     Y_LAST      = YW'(SCAN_ROWS - 1);

  localparam logic [1:0] ST_SHIFT = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_SHOW  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [YW-1:0] r_y;
  logic [ZW-1:0] r_z;
  logic          r_front_sel;
  logic          r_swap_pending;
  logic [15:0]   r_frame_cnt;
  logic [7:0]    r_bright;
  logic          r_ctrl_done;
  logic [31:0]   r_ctrl_rdat;
  logic          r_r0, r_g0, r_b0, r_r1, r_g1, r_b1;
  logic [4:0]    r_panel_addr;
  logic          r_panel_clk, r_panel_stb, r_panel_oe;

  logic [BITS_PER_CHANNEL-1:0] r_mem_r [DEPTH];
  logic [BITS_PER_CHANNEL-1:0] r_mem_g [DEPTH];
  logic [BITS_PER_CHANNEL-1:0] r_mem_b [DEPTH];

  // Bus decode: an access is accepted on the edge that raises ctrl_done
  logic          w_access, w_back, w_pix_ok, w_ctrl_hit, w_swap_req;
  logic [31:0]   w_pix_idx, w_rd_val;
  logic [MW-1:0] w_wr_idx;
  logic          w_unused;
  assign w_access   = ((|ctrl_wr) || ctrl_rd) && !r_ctrl_done;
  assign w_back     = DB ? ~r_front_sel : r_front_sel;
  assign w_pix_idx  = {19'b0, ctrl_addr[14:2]};
  assign w_pix_ok   = !ctrl_addr[15] && (w_pix_idx < NPIX32);
  assign w_wr_idx   = MW'((w_back ? NPIX32 : 32'd0) + w_pix_idx);
  assign w_ctrl_hit = w_access && (|ctrl_wr) && (ctrl_addr == 16'h8000);
  assign w_swap_req = w_ctrl_hit && ctrl_wr[0] && ctrl_wdat[0] && DB;
  assign w_unused   = ^{ctrl_wdat[31:24], ctrl_addr[1:0]};

  // Scan datapath: pixel fetch addresses, SHOW length and plane/frame completion
  logic [31:0]   w_col, w_front_off;
  logic [MW-1:0] w_top_idx, w_bot_idx;
  logic [CW-1:0] w_show_len;
  logic          w_show_done, w_plane_done, w_frame_end;
  assign w_col        = 32'(r_cnt[CW-1:1]);
  assign w_front_off  = r_front_sel ? NPIX32 : 32'd0;
  assign w_top_idx    = MW'(w_front_off + 32'(r_y) * NCOL32 + w_col);
  assign w_bot_idx    = MW'(w_front_off + 32'(r_y) * NCOL32 + w_col + HALF32);
  assign w_show_len   = CW'(r_bright) << r_z;
  assign w_show_done  = (r_cnt + CW'(1)) >= w_show_len;
  assign w_plane_done = ((r_state == ST_LATCH) && (r_bright == 8'd0)) ||
                        ((r_state == ST_SHOW) && w_show_done);
  assign w_frame_end  = w_plane_done && (r_z == Z_LAST) && (r_y == Y_LAST);

  // Register read mux
  always_comb begin
    w_rd_val = 32'd0;
    if (ctrl_addr == 16'h8000) w_rd_val = {16'b0, r_bright, 7'b0, r_swap_pending};
    else if (ctrl_addr == 16'h8004) w_rd_val = {r_frame_cnt, 15'b0, r_front_sel};
  end

  // Bus handshake, read data capture and BRIGHT register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl_done <= 1'b0;
      r_ctrl_rdat <= 32'd0;
      r_bright    <= 8'(BRIGHT_RESET);
    end else begin
      r_ctrl_done <= w_access;
      if (w_access && ctrl_rd) r_ctrl_rdat <= w_rd_val;
      if (w_ctrl_hit && ctrl_wr[1]) r_bright <= ctrl_wdat[15:8];
    end
  end

  // Frame buffer writes into the back buffer; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && w_access && w_pix_ok) begin
      if (ctrl_wr[2]) r_mem_r[w_wr_idx] <= ctrl_wdat[23 -: BITS_PER_CHANNEL];
      if (ctrl_wr[1]) r_mem_g[w_wr_idx] <= ctrl_wdat[15 -: BITS_PER_CHANNEL];
      if (ctrl_wr[0]) r_mem_b[w_wr_idx] <= ctrl_wdat[7 -: BITS_PER_CHANNEL];
    end
  end

  // Buffer swap and frame counter; a SWAP landing on frame end stays pending
  always_ff @(posedge clk) begin
    if (reset) begin
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_frame_cnt    <= 16'd0;
    end else begin
      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        if (r_swap_pending && DB) begin
          r_front_sel    <= ~r_front_sel;
          r_swap_pending <= 1'b0;
        end
      end
      if (w_swap_req) r_swap_pending <= 1'b1;
    end
  end

  // Scan FSM: SHIFT -> BLANK -> LATCH -> SHOW, stepping plane z then row y
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_SHIFT;
      r_cnt   <= '0;
      r_y     <= '0;
      r_z     <= '0;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (r_cnt == SHIFT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_BLANK;
          end else r_cnt <= r_cnt + CW'(1);
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_LATCH;
          end else r_cnt <= r_cnt + CW'(1);
        end
        ST_LATCH: begin
          r_cnt   <= '0;
          r_state <= (r_bright == 8'd0) ? ST_SHIFT : ST_SHOW;
        end
        default: begin
          if (w_show_done) begin
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end else r_cnt <= r_cnt + CW'(1);
        end
      endcase
      if (w_plane_done) begin
        if (r_z == Z_LAST) begin
          r_z <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
        end else r_z <= r_z + ZW'(1);
      end
    end
  end

  // Registered panel outputs, one cycle behind the FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      {r_r0, r_g0, r_b0, r_r1, r_g1, r_b1} <= 6'b0;
      r_panel_addr <= 5'd0;
      r_panel_clk  <= 1'b0;
      r_panel_stb  <= 1'b0;
      r_panel_oe   <= 1'b1;
    end else begin
      if (r_state == ST_SHIFT) begin
        r_r0 <= r_mem_r[w_top_idx][r_z];
        r_g0 <= r_mem_g[w_top_idx][r_z];
        r_b0 <= r_mem_b[w_top_idx][r_z];
        r_r1 <= r_mem_r[w_bot_idx][r_z];
        r_g1 <= r_mem_g[w_bot_idx][r_z];
        r_b1 <= r_mem_b[w_bot_idx][r_z];
      end else begin
        {r_r0, r_g0, r_b0, r_r1, r_g1, r_b1} <= 6'b0;
      end
      if (r_state == ST_BLANK) r_panel_addr <= 5'(r_y);
      r_panel_clk <= (r_state == ST_SHIFT) && r_cnt[0];
      r_panel_stb <= (r_state == ST_LATCH);
      r_panel_oe  <= (r_state != ST_SHOW);
    end
  end

  assign ctrl_done  = r_ctrl_done;
  assign ctrl_rdat  = r_ctrl_rdat;
  assign panel_r0   = r_r0;
  assign panel_g0   = r_g0;
  assign panel_b0   = r_b0;
  assign panel_r1   = r_r1;
  assign panel_g1   = r_g1;
  assign panel_b1   = r_b1;
  assign panel_addr = r_panel_addr;
  assign panel_clk  = r_panel_clk;
  assign panel_stb  = r_panel_stb;
  assign panel_oe   = r_panel_oe;

endmodule
